line_sequencer: RTL and testbench



---
 rtl/line_sequencer_if.sv | 48 ++++
 rtl/line_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_line_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/line_sequencer_if.sv
// Bundle between the line sequencer and its neighbours: command intake,
// Bresenham error-unit control/return, and the pixel output stream.
interface line_sequencer_if #(
  parameter int WIDTH = 10
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_x0;
  logic [WIDTH-1:0] cmd_y0;
  logic [WIDTH-1:0] cmd_x1;
  logic [WIDTH-1:0] cmd_y1;

  logic             eu_rst;
  logic             eu_start;
  logic [WIDTH-1:0] eu_deltax;
  logic [WIDTH-1:0] eu_deltay;
  logic [WIDTH-1:0] eu_ystep;
  logic [WIDTH-1:0] eu_x0;
  logic [WIDTH-1:0] eu_xcount;
  logic             eu_last_count;
  logic [WIDTH-1:0] eu_y;
  logic             eu_step;

  logic             pix_valid;
  logic             pix_ready;
  logic [WIDTH-1:0] pix_x;
  logic [WIDTH-1:0] pix_y;
  logic             pix_last;
  logic             busy;

  modport master (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1,
    input  eu_y, eu_step, pix_ready,
    output cmd_ready, eu_rst, eu_start,
    output eu_deltax, eu_deltay, eu_ystep, eu_x0,
    output eu_xcount, eu_last_count,
    output pix_valid, pix_x, pix_y, pix_last, busy
  );

  modport slave (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1,
    output eu_y, eu_step, pix_ready,
    input  cmd_ready, eu_rst, eu_start,
    input  eu_deltax, eu_deltay, eu_ystep, eu_x0,
    input  eu_xcount, eu_last_count,
    input  pix_valid, pix_x, pix_y, pix_last, busy
  );
endinterface

// File: rtl/line_sequencer.sv
// Line command sequencer: octant setup, error-unit stepping, pixel FIFO.
// Optional SCREEN_CLIP_EN drops pixels outside H_RES x V_RES.
module line_sequencer #(
  parameter int WIDTH     = 10,
  parameter int OUT_DEPTH = 2
`ifdef SCREEN_CLIP_EN
  ,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480
`endif
) (
  input logic clk,
  input logic rst,
  line_sequencer_if.master bus
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int EW = 2 * WIDTH + 1;
  localparam logic [AW:0] START_LIM = (AW+1)'(OUT_DEPTH - 1);
  localparam logic [AW:0] FULL_LIM  = (AW+1)'(OUT_DEPTH);

  typedef enum logic [2:0] {
    IDLE, SETUP, CLEAR, RUN, DRAIN
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] x0, y0, x1, y1;
  logic             steep;
  logic [WIDTH-1:0] deltax, deltay, ystep;
  logic [WIDTH-1:0] ox0, ox1, xcount;

  logic [EW-1:0] mem [OUT_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [EW-1:0] head;

  logic          start, step_ok, last_cnt;
  logic          push, pop, drained;
  logic [EW-1:0] push_data;
  logic [WIDTH-1:0] px, py;

  logic signed [WIDTH:0] dx, dy, adx, ady;
  logic             s_steep, swap;
  logic [WIDTH-1:0] sx0, sy0, sx1, sy1;
  logic [WIDTH-1:0] ax0, ay0, ax1, ay1;

  always_comb begin
    dx      = $signed({1'b0, x1}) - $signed({1'b0, x0});
    dy      = $signed({1'b0, y1}) - $signed({1'b0, y0});
    adx     = dx[WIDTH] ? -dx : dx;
    ady     = dy[WIDTH] ? -dy : dy;
    s_steep = ady > adx;
    sx0     = s_steep ? y0 : x0;
    sy0     = s_steep ? x0 : y0;
    sx1     = s_steep ? y1 : x1;
    sy1     = s_steep ? x1 : y1;
    swap    = sx0 > sx1;
    ax0     = swap ? sx1 : sx0;
    ay0     = swap ? sy1 : sy0;
    ax1     = swap ? sx0 : sx1;
    ay1     = swap ? sy0 : sy1;
  end

  assign last_cnt = (state == RUN) && (xcount == ox1);
  assign px       = steep ? bus.eu_y : xcount;
  assign py       = steep ? xcount : bus.eu_y;
  assign pop      = (count != '0) && bus.pix_ready;

  always_comb begin
    state_nx      = state;
    start         = 1'b0;
    step_ok       = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.eu_rst    = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nx = SETUP;
      end
      SETUP: state_nx = CLEAR;
      CLEAR: begin
        bus.eu_rst = 1'b1;
        state_nx   = RUN;
      end
      RUN: begin
        // keep one slot free so a step can always be absorbed
        start   = count < START_LIM;
        step_ok = start && bus.eu_step;
        if (step_ok && last_cnt) state_nx = DRAIN;
      end
      DRAIN: if (drained) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef SCREEN_CLIP_EN
  localparam logic [WIDTH:0] H_LIM = (WIDTH+1)'(H_RES);
  localparam logic [WIDTH:0] V_LIM = (WIDTH+1)'(V_RES);

  logic               pend_valid, pend_load, pend_clear, in_b;
  logic [2*WIDTH-1:0] pend_data;

  assign in_b    = ({1'b0, px} < H_LIM) && ({1'b0, py} < V_LIM);
  assign drained = (count == '0) && !pend_valid;

  // in-bounds pixels are contiguous along a line, so holding one back
  // until the next step tells whether it is the last visible one
  always_comb begin
    push       = 1'b0;
    push_data  = '0;
    pend_load  = 1'b0;
    pend_clear = 1'b0;
    if (step_ok) begin
      if (in_b) begin
        pend_load = 1'b1;
        if (pend_valid) begin
          push      = 1'b1;
          push_data = {pend_data, 1'b0};
        end
      end else if (pend_valid) begin
        push       = 1'b1;
        push_data  = {pend_data, 1'b1};
        pend_clear = 1'b1;
      end
    end else if (state == DRAIN && pend_valid && count < FULL_LIM) begin
      push       = 1'b1;
      push_data  = {pend_data, 1'b1};
      pend_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else if (pend_load) begin
      pend_valid <= 1'b1;
      pend_data  <= {px, py};
    end else if (pend_clear) begin
      pend_valid <= 1'b0;
    end
  end
`else
  assign drained   = (count == '0);
  assign push      = step_ok;
  assign push_data = {px, py, last_cnt};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      x0     <= '0;
      y0     <= '0;
      x1     <= '0;
      y1     <= '0;
      steep  <= 1'b0;
      deltax <= '0;
      deltay <= '0;
      ystep  <= '0;
      ox0    <= '0;
      ox1    <= '0;
      xcount <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.cmd_valid) begin
        x0 <= bus.cmd_x0;
        y0 <= bus.cmd_y0;
        x1 <= bus.cmd_x1;
        y1 <= bus.cmd_y1;
      end
      if (state == SETUP) begin
        steep  <= s_steep;
        deltax <= ax1 - ax0;
        deltay <= (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
        ystep  <= (ay0 < ay1) ? WIDTH'(1) : '1;
        ox0    <= ax0;
        ox1    <= ax1;
        xcount <= ax0;
      end
      if (step_ok && !last_cnt) xcount <= xcount + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

  assign bus.eu_start      = start;
  assign bus.eu_deltax     = deltax;
  assign bus.eu_deltay     = deltay;
  assign bus.eu_ystep      = ystep;
  assign bus.eu_x0         = ox0;
  assign bus.eu_xcount     = xcount;
  assign bus.eu_last_count = last_cnt;
  assign bus.pix_valid     = (count != '0);
  assign bus.pix_x         = head[EW-1 -: WIDTH];
  assign bus.pix_y         = head[WIDTH -: WIDTH];
  assign bus.pix_last      = head[0];
  assign bus.busy          = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_line_sequencer.sv
// Random and directed line commands against a Bresenham pixel-list model;
// a small error-unit stub answers eu_xcount with the ideal minor coordinate.
module tb_line_sequencer;
  localparam int W  = 10;
  localparam int HR = 640;
  localparam int VR = 480;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_sequencer_if #(.WIDTH(W)) bus();

  line_sequencer #(.WIDTH(W), .OUT_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int x;
    int y;
    bit last;
  } pix_t;

  pix_t expq[$];
  int total = 0;
  int bad   = 0;
  int m_steep, a0, b0, m_dx, m_dy, m_ys;
  bit stall_seen;

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int minor(int i, int dx, int dy);
    if (dx == 0) return 0;
    return (2 * dy * i + dx) / (2 * dx);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // expected pixel list from the line's endpoints
  task automatic model(int x0, int y0, int x1, int y1);
    int p0, q0, p1, q1, t, mj, mn;
    pix_t p;
    m_steep = int'(iabs(y1 - y0) > iabs(x1 - x0));
    if (m_steep != 0) begin
      p0 = y0; q0 = x0; p1 = y1; q1 = x1;
    end else begin
      p0 = x0; q0 = y0; p1 = x1; q1 = y1;
    end
    if (p0 > p1) begin
      t = p0; p0 = p1; p1 = t;
      t = q0; q0 = q1; q1 = t;
    end
    a0   = p0;
    b0   = q0;
    m_dx = p1 - p0;
    m_dy = iabs(q1 - q0);
    m_ys = (q0 < q1) ? 1 : -1;
    expq.delete();
    for (int i = 0; i <= m_dx; i++) begin
      mj = a0 + i;
      mn = b0 + m_ys * minor(i, m_dx, m_dy);
      p.x = (m_steep != 0) ? mn : mj;
      p.y = (m_steep != 0) ? mj : mn;
      p.last = 1'b0;
`ifdef SCREEN_CLIP_EN
      if (p.x >= HR || p.y >= VR) continue;
`endif
      expq.push_back(p);
    end
    if (expq.size() > 0) expq[expq.size() - 1].last = 1'b1;
  endtask

  task automatic drive_eu();
    int i;
    i = int'(bus.eu_xcount) - a0;
    if (i < 0 || i > m_dx) i = 0;
    bus.eu_y    = W'(b0 + m_ys * minor(i, m_dx, m_dy));
    bus.eu_step = ($urandom_range(0, 3) != 0);
  endtask

  task automatic run_line(int x0, int y0, int x1, int y1,
                          int rmode, int rst_after, string tag);
    int popped;
    pix_t e;
    model(x0, y0, x1, y1);
    stall_seen = 1'b0;
    popped = 0;
    @(negedge clk);
    check({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_x0 = W'(x0);
    bus.cmd_y0 = W'(y0);
    bus.cmd_x1 = W'(x1);
    bus.cmd_y1 = W'(y1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check({tag, ".eu_rst"}, 32'(bus.eu_rst), 1);
    check({tag, ".eu_start_clr"}, 32'(bus.eu_start), 0);
    check({tag, ".deltax"}, 32'(bus.eu_deltax), m_dx);
    check({tag, ".deltay"}, 32'(bus.eu_deltay), m_dy);
    check({tag, ".ystep"}, 32'(bus.eu_ystep),
          (m_ys == 1) ? 1 : (1 << W) - 1);
    check({tag, ".eu_x0"}, 32'(bus.eu_x0), a0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case (rmode)
        0:       bus.pix_ready = 1'b1;
        1:       bus.pix_ready = ((cyc / 3) % 2) == 0;
        default: bus.pix_ready = 1'($urandom_range(0, 1));
      endcase
      drive_eu();
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_x0 = W'($urandom);
      bus.cmd_y0 = W'($urandom);
      #1;
      if (!bus.busy && expq.size() == 0) break;
      if (!bus.eu_start && expq.size() > 1) stall_seen = 1'b1;
      if (bus.pix_valid && bus.pix_ready) begin
        if (expq.size() == 0) begin
          check({tag, ".extra_pixel"}, 32'(bus.pix_valid), 0);
        end else begin
          e = expq.pop_front();
          check({tag, ".pix_x"}, 32'(bus.pix_x), e.x);
          check({tag, ".pix_y"}, 32'(bus.pix_y), e.y);
          check({tag, ".pix_last"}, 32'(bus.pix_last), 32'(e.last));
          popped++;
        end
      end
      @(negedge clk);
      if (rst_after > 0 && popped == rst_after) begin
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check({tag, ".rst_pix_valid"}, 32'(bus.pix_valid), 0);
        check({tag, ".rst_busy"}, 32'(bus.busy), 0);
        check({tag, ".rst_cmd_ready"}, 32'(bus.cmd_ready), 1);
        check({tag, ".rst_eu_start"}, 32'(bus.eu_start), 0);
        expq.delete();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    bus.cmd_valid = 1'b0;
    check({tag, ".remaining"}, 32'(expq.size()), 0);
    check({tag, ".busy_end"}, 32'(bus.busy), 0);
    check({tag, ".cmd_ready_end"}, 32'(bus.cmd_ready), 1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_x0    = '0;
    bus.cmd_y0    = '0;
    bus.cmd_x1    = '0;
    bus.cmd_y1    = '0;
    bus.eu_y      = '0;
    bus.eu_step   = 1'b0;
    bus.pix_ready = 1'b0;
    a0 = 0; b0 = 0; m_dx = 0; m_dy = 0; m_ys = 1;

    repeat (3) @(negedge clk);
    check("reset.cmd_ready", 32'(bus.cmd_ready), 1);
    check("reset.pix_valid", 32'(bus.pix_valid), 0);
    check("reset.busy", 32'(bus.busy), 0);
    check("reset.eu_rst", 32'(bus.eu_rst), 0);
    check("reset.eu_start", 32'(bus.eu_start), 0);
    check("reset.eu_last", 32'(bus.eu_last_count), 0);
    check("reset.eu_xcount", 32'(bus.eu_xcount), 0);
    rst = 1'b0;

    run_line(2, 3, 6, 5, 0, 0, "shallow");
    run_line(5, 1, 1, 9, 2, 0, "steep_rev");
    run_line(7, 7, 7, 7, 0, 0, "point");
    run_line(0, 0, 20, 0, 1, 0, "horiz_bp");
    check("horiz_bp.stall", 32'(stall_seen), 1);
    run_line(4, 0, 4, 12, 2, 0, "vertical");
    run_line(0, 0, 15, 9, 0, 4, "midrst");
    run_line(0, 0, 3, 3, 0, 0, "diag");
`ifdef SCREEN_CLIP_EN
    run_line(636, 0, 643, 0, 0, 0, "clip");
`endif
    for (int k = 0; k < 20; k++) begin
      run_line($urandom_range(0, 40), $urandom_range(0, 40),
               $urandom_range(0, 40), $urandom_range(0, 40),
               $urandom_range(0, 2), 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
